// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: shared types and helpers for the VRAM scan-out / CPU arbiter.
package vram_arb_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, CAPT, ACK} rd_state_e;
   localparam int DISP_LAT = 2;
   // Nibble replication gives full-scale 8-bit channels (F -> FF, 0 -> 00).
   function automatic logic [23:0] rgb444_to_888(input logic [11:0] c);
      return {c[11:8], c[11:8], c[7:4], c[7:4], c[3:0], c[3:0]};
   endfunction
endpackage

// File: rtl/vram_scan_arbiter_if.sv
// vram_scan_arbiter_if: CPU load/store port; the CPU holds req and its fields until ack.
interface vram_scan_arbiter_if #(parameter int AW = 19, parameter int DW = 12);
   logic          req;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          ack;
   logic [DW-1:0] rdata;
   modport master (output req, we, addr, wdata, input ack, rdata);
   modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/vram_wr_fifo.sv
// vram_wr_fifo: small write-posting FIFO; the caller never pushes when full or pops when empty.
module vram_wr_fifo #(parameter int DEPTH = 4, parameter int W = 31) (
   input  logic                   pclk,
   input  logic                   reset,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [W-1:0]           din_i,
   output logic [W-1:0]           dout_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] level_o
);
   localparam int PW = $clog2(DEPTH);
   logic [W-1:0] mem_q [DEPTH];
   logic [PW:0]  wp_q, rp_q;
   always_ff @(posedge pclk or posedge reset)
      if (reset) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         if (push_i) wp_q <= wp_q + 1'b1;
         if (pop_i) rp_q <= rp_q + 1'b1;
      end
   always_ff @(posedge pclk)
      if (push_i) mem_q[wp_q[PW-1:0]] <= din_i;
   assign level_o = wp_q - rp_q;
   assign full_o  = level_o == (PW+1)'(DEPTH);
   assign empty_o = wp_q == rp_q;
   assign dout_o  = mem_q[rp_q[PW-1:0]];
endmodule

// File: rtl/vram_scan_arbiter.sv
// vram_scan_arbiter: shares one single-port VRAM between display scan-out (never stalled),
// a posted CPU write FIFO drained in blanking, and CPU reads ordered behind earlier writes.
module vram_scan_arbiter
   import vram_arb_pkg::*;
#(
   parameter int AW    = 19,
   parameter int DW    = 12,
   parameter int DEPTH = 4
) (
   input  logic                   pclk,
   input  logic                   reset,
   input  logic                   disp_req_i,
   input  logic [AW-1:0]          disp_addr_i,
   output logic [23:0]            disp_data_o,
   vram_scan_arbiter_if.slave     cpu,
   output logic [$clog2(DEPTH):0] fifo_level_o,
   output logic                   mem_en_o,
   output logic                   mem_we_o,
   output logic [AW-1:0]          mem_addr_o,
   output logic [DW-1:0]          mem_wdata_o,
   input  logic [DW-1:0]          mem_rdata_i
);
   logic             full, empty, push, pop, rd_go, disp_v_q, ack_q;
   logic [AW+DW-1:0] head;
   logic [DW-1:0]    rdata_q;
   logic [23:0]      disp_data_q, disp_data_d;
   rd_state_e        st_q;

   // Full is the registered occupancy, so a same-cycle pop never frees a slot for a push.
   assign push  = cpu.req & cpu.we & ~ack_q & ~full;
   assign pop   = ~disp_req_i & ~empty;
   assign rd_go = (st_q == ISSUE) & ~disp_req_i & ~pop;

   vram_wr_fifo #(.DEPTH(DEPTH), .W(AW + DW)) u_fifo (
      .pclk    (pclk),
      .reset   (reset),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   ({cpu.addr, cpu.wdata}),
      .dout_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .level_o (fifo_level_o)
   );

   // Reset gates the bus combinationally so the RAM sees no access during reset.
   assign mem_en_o    = ~reset & (disp_req_i | pop | rd_go);
   assign mem_we_o    = ~reset & pop;
   assign mem_addr_o  = reset ? '0 : disp_req_i ? disp_addr_i : pop ? head[AW+DW-1:DW] : rd_go ? cpu.addr : '0;
   assign mem_wdata_o = (~reset & pop) ? head[DW-1:0] : '0;

   assign disp_data_d = disp_v_q ? rgb444_to_888(mem_rdata_i) : '0;
   always_ff @(posedge pclk or posedge reset)
      if (reset) begin
         disp_v_q    <= 1'b0;
         disp_data_q <= '0;
      end else begin
         disp_v_q    <= disp_req_i;
         disp_data_q <= disp_data_d;
      end
   assign disp_data_o = disp_data_q;

   always_ff @(posedge pclk or posedge reset)
      if (reset) begin
         st_q    <= IDLE;
         ack_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         ack_q <= push | (st_q == CAPT);
         case (st_q)
            IDLE:    if (cpu.req & ~cpu.we & ~ack_q & empty & ~push) st_q <= ISSUE;
            ISSUE:   if (rd_go) st_q <= CAPT;
            CAPT: begin
               rdata_q <= mem_rdata_i;
               st_q    <= ACK;
            end
            default: st_q <= IDLE;
         endcase
      end
   assign cpu.ack   = ack_q;
   assign cpu.rdata = rdata_q;
endmodule

// File: tb/tb_vram_scan_arbiter.sv
// tb_vram_scan_arbiter: directed checks of display latency, write posting, read ordering and reset.
module tb_vram_scan_arbiter;
   import vram_arb_pkg::*;
   logic        pclk = 1'b0;
   logic        reset, disp_req, mem_en, mem_we;
   logic [18:0] disp_addr, mem_addr;
   logic [23:0] disp_data;
   logic [2:0]  fifo_level;
   logic [11:0] mem_wdata, mem_rdata;
   logic [11:0] vram [logic [18:0]];
   int          n_tests = 0, n_fail = 0;

   vram_scan_arbiter_if #(.AW(19), .DW(12)) cpu_if ();

   vram_scan_arbiter #(.AW(19), .DW(12), .DEPTH(4)) dut (
      .pclk         (pclk),
      .reset        (reset),
      .disp_req_i   (disp_req),
      .disp_addr_i  (disp_addr),
      .disp_data_o  (disp_data),
      .cpu          (cpu_if),
      .fifo_level_o (fifo_level),
      .mem_en_o     (mem_en),
      .mem_we_o     (mem_we),
      .mem_addr_o   (mem_addr),
      .mem_wdata_o  (mem_wdata),
      .mem_rdata_i  (mem_rdata)
   );

   always #5 pclk = ~pclk;

   always @(posedge pclk)
      if (mem_en) begin
         if (mem_we) vram[mem_addr] = mem_wdata;
         else mem_rdata <= vram.exists(mem_addr) ? vram[mem_addr] : 12'h000;
      end

   function automatic logic [23:0] exp888(input logic [11:0] c);
      logic [7:0] r, g, b;
      r = 8'(c[11:8]) * 8'd17;
      g = 8'(c[7:4]) * 8'd17;
      b = 8'(c[3:0]) * 8'd17;
      return {r, g, b};
   endfunction

   task automatic cycle;
      @(posedge pclk);
      #1;
   endtask

   task automatic cpu_write(input logic [18:0] a, input logic [11:0] d, output bit acked);
      cpu_if.req = 1'b1; cpu_if.we = 1'b1; cpu_if.addr = a; cpu_if.wdata = d;
      acked = 1'b0;
      for (int i = 0; i < 20 && !acked; i++) begin
         @(negedge pclk);
         if (cpu_if.ack) acked = 1'b1;
         cycle();
      end
      cpu_if.req = 1'b0;
   endtask

   task automatic test_display;
      logic [23:0] exp [6];
      exp = '{24'hFF8800, 24'h000000, 24'h00FF00, 24'h112233, 24'h000000, 24'h000000};
      vram[0] = 12'hF80; vram[1] = 12'h000; vram[2] = 12'h0F0; vram[3] = 12'h123;
      for (int k = 0; k < 8; k++) begin
         disp_req = k < 4;
         disp_addr = 19'(k);
         @(negedge pclk);
         n_tests++;
         if ({mem_en, mem_we, mem_addr} !== {k < 4, 1'b0, k < 4 ? 19'(k) : 19'h0}) begin
            n_fail++; $display("FAIL disp_issue k=%0d: got en=%b we=%b addr=%h", k, mem_en, mem_we, mem_addr);
         end
         if (k >= 2) begin
            n_tests++;
            if (disp_data !== exp[k-2]) begin
               n_fail++; $display("FAIL disp_data k=%0d: got %h expected %h", k, disp_data, exp[k-2]);
            end
         end
         cycle();
      end
   endtask

   task automatic test_write_buffer;
      logic [18:0] wa [5];
      logic [11:0] wd [5];
      bit ok;
      int ack_at = -1;
      for (int i = 0; i < 5; i++) begin
         wa[i] = 19'h40 + 19'(i);
         wd[i] = 12'h111 * 12'(i + 1);
      end
      disp_req = 1'b1; disp_addr = 19'h10;
      for (int i = 0; i < 4; i++) begin
         cpu_write(wa[i], wd[i], ok);
         n_tests++;
         if (!ok) begin n_fail++; $display("FAIL wbuf_ack%0d: got no ack, expected ack", i); end
      end
      n_tests++;
      if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL wbuf_level_full: got %0d expected 4", fifo_level); end
      cpu_if.req = 1'b1; cpu_if.we = 1'b1; cpu_if.addr = wa[4]; cpu_if.wdata = wd[4];
      for (int j = 0; j < 4; j++) begin
         @(negedge pclk);
         n_tests++;
         if ({cpu_if.ack, fifo_level, mem_we} !== {1'b0, 3'd4, 1'b0}) begin
            n_fail++; $display("FAIL wbuf_stall%0d: got ack=%b level=%0d we=%b expected 0/4/0", j, cpu_if.ack, fifo_level, mem_we);
         end
         cycle();
      end
      for (int j = 0; j < 3; j++) begin
         disp_req = 1'b0;
         @(negedge pclk);
         n_tests++;
         if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, wa[j], wd[j]}) begin
            n_fail++; $display("FAIL wbuf_drain%0d: got we=%b %h/%h expected %h/%h", j, mem_we, mem_addr, mem_wdata, wa[j], wd[j]);
         end
         if (cpu_if.ack) ack_at = j;
         cycle();
         if (ack_at >= 0) cpu_if.req = 1'b0;
      end
      n_tests++;
      if (ack_at !== 2) begin n_fail++; $display("FAIL wbuf_fifth_ack: got drain cycle %0d expected 2", ack_at); end
      disp_req = 1'b1;
      @(negedge pclk);
      n_tests++;
      if (fifo_level !== 3'd2) begin n_fail++; $display("FAIL wbuf_level_mid: got %0d expected 2", fifo_level); end
      cycle();
      for (int j = 0; j < 2; j++) begin
         disp_req = 1'b0;
         @(negedge pclk);
         n_tests++;
         if ({mem_we, mem_addr, mem_wdata} !== {1'b1, wa[3+j], wd[3+j]}) begin
            n_fail++; $display("FAIL wbuf_tail%0d: got %h/%h expected %h/%h", j, mem_addr, mem_wdata, wa[3+j], wd[3+j]);
         end
         cycle();
      end
      n_tests++;
      if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL wbuf_level_empty: got %0d expected 0", fifo_level); end
   endtask

   task automatic test_raw;
      bit ok, got = 1'b0;
      int w = -1, iss = -1, a = -1;
      logic [11:0] rd = '0;
      disp_req = 1'b1; disp_addr = 19'h7;
      cpu_write(19'h100, 12'hABC, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL raw_write_ack: got no ack, expected ack"); end
      for (int k = 0; k < 20 && !got; k++) begin
         disp_req = k < 3;
         cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 19'h100;
         @(negedge pclk);
         if (mem_en && mem_we && mem_addr == 19'h100 && w < 0) w = k;
         if (mem_en && !mem_we && mem_addr == 19'h100 && iss < 0) iss = k;
         if (cpu_if.ack) begin got = 1'b1; a = k; rd = cpu_if.rdata; end
         cycle();
      end
      cpu_if.req = 1'b0;
      n_tests++;
      if (w !== 3) begin n_fail++; $display("FAIL raw_drain_cycle: got %0d expected 3", w); end
      n_tests++;
      if (iss !== 5) begin n_fail++; $display("FAIL raw_issue_cycle: got %0d expected 5", iss); end
      n_tests++;
      if (a !== 7) begin n_fail++; $display("FAIL raw_ack_cycle: got %0d expected 7", a); end
      n_tests++;
      if (rd !== 12'hABC) begin n_fail++; $display("FAIL raw_rdata: got %h expected abc", rd); end
   endtask

   task automatic test_starvation;
      bit got = 1'b0;
      int iss = -1, a = -1;
      logic [11:0] rd = '0;
      logic [23:0] exp;
      for (int i = 0; i < 10; i++) vram[19'h10 + 19'(i)] = 12'h111 * 12'(i + 1);
      vram[19'h200] = 12'h5A7;
      for (int k = 0; k < 14; k++) begin
         disp_req = k < 10;
         disp_addr = 19'h10 + 19'(k);
         cpu_if.req = !got; cpu_if.we = 1'b0; cpu_if.addr = 19'h200;
         @(negedge pclk);
         if (k < 10) begin
            n_tests++;
            if ({mem_en, mem_we, mem_addr} !== {2'b10, 19'h10 + 19'(k)}) begin
               n_fail++; $display("FAIL starve_disp_slot k=%0d: got en=%b we=%b addr=%h", k, mem_en, mem_we, mem_addr);
            end
         end
         if (k >= 2) begin
            exp = (k - 2 < 10) ? exp888(12'h111 * 12'(k - 1)) : 24'h0;
            n_tests++;
            if (disp_data !== exp) begin
               n_fail++; $display("FAIL starve_disp_data k=%0d: got %h expected %h", k, disp_data, exp);
            end
         end
         if (mem_en && !mem_we && mem_addr == 19'h200 && iss < 0) iss = k;
         if (cpu_if.ack && !got) begin got = 1'b1; a = k; rd = cpu_if.rdata; end
         cycle();
      end
      cpu_if.req = 1'b0;
      n_tests++;
      if (iss !== 10) begin n_fail++; $display("FAIL starve_issue_cycle: got %0d expected 10", iss); end
      n_tests++;
      if (a !== 12) begin n_fail++; $display("FAIL starve_ack_cycle: got %0d expected 12", a); end
      n_tests++;
      if (rd !== 12'h5A7) begin n_fail++; $display("FAIL starve_rdata: got %h expected 5a7", rd); end
   endtask

   task automatic test_reset;
      bit ok;
      disp_req = 1'b1; disp_addr = 19'h10;
      cpu_write(19'h300, 12'h001, ok);
      cpu_write(19'h301, 12'h002, ok);
      cpu_if.req = 1'b1; cpu_if.we = 1'b1; cpu_if.addr = 19'h302; cpu_if.wdata = 12'h003;
      cycle();
      #2 reset = 1'b1;
      #1;
      n_tests++;
      if (mem_en !== 1'b0) begin n_fail++; $display("FAIL rst_mem_en: got %b expected 0", mem_en); end
      n_tests++;
      if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %b expected 0", mem_we); end
      n_tests++;
      if (mem_addr !== 19'h0) begin n_fail++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); end
      n_tests++;
      if (mem_wdata !== 12'h0) begin n_fail++; $display("FAIL rst_mem_wdata: got %h expected 0", mem_wdata); end
      n_tests++;
      if (disp_data !== 24'h0) begin n_fail++; $display("FAIL rst_disp_data: got %h expected 0", disp_data); end
      n_tests++;
      if (cpu_if.ack !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_ack: got %b expected 0", cpu_if.ack); end
      n_tests++;
      if (cpu_if.rdata !== 12'h0) begin n_fail++; $display("FAIL rst_cpu_rdata: got %h expected 0", cpu_if.rdata); end
      n_tests++;
      if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL rst_fifo_level: got %0d expected 0", fifo_level); end
      cycle();
      reset = 1'b0; cpu_if.req = 1'b0; disp_req = 1'b0;
      repeat (2) cycle();
   endtask

   task automatic test_reset_mid_read;
      cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 19'h200; disp_req = 1'b0;
      cycle();
      @(negedge pclk);
      n_tests++;
      if ({mem_en, mem_we, mem_addr} !== {2'b10, 19'h200}) begin
         n_fail++; $display("FAIL rmr_issue: got en=%b we=%b addr=%h expected read of 200", mem_en, mem_we, mem_addr);
      end
      cycle();
      #2 reset = 1'b1;
      #1;
      n_tests++;
      if ({mem_en, cpu_if.ack} !== 2'b00) begin n_fail++; $display("FAIL rmr_outputs: got en=%b ack=%b expected 0/0", mem_en, cpu_if.ack); end
      n_tests++;
      if (dut.st_q !== IDLE) begin n_fail++; $display("FAIL rmr_state: got %0d expected IDLE", dut.st_q); end
      cycle();
      reset = 1'b0; cpu_if.req = 1'b0;
      for (int j = 0; j < 5; j++) begin
         @(negedge pclk);
         n_tests++;
         if ({mem_en, cpu_if.ack} !== 2'b00) begin
            n_fail++; $display("FAIL rmr_after%0d: got en=%b ack=%b expected 0/0", j, mem_en, cpu_if.ack);
         end
         cycle();
      end
   endtask

   initial begin
      reset = 1'b1; disp_req = 1'b0; disp_addr = '0;
      cpu_if.req = 1'b0; cpu_if.we = 1'b0; cpu_if.addr = '0; cpu_if.wdata = '0;
      repeat (2) cycle();
      reset = 1'b0;
      repeat (2) cycle();
      test_display();
      test_write_buffer();
      test_raw();
      test_starvation();
      test_reset();
      test_reset_mid_read();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
